// File: rtl/io_module_if.sv
// CPU-side memory-mapped I/O bus between the datapath and io_module.
// The datapath drives address, store data and memory data; io_module returns writeback data.
interface io_module_if;
    logic        IORead;
    logic        IOWrite;
    logic [31:0] ALU_result;
    logic [31:0] Read_data_2;
    logic [31:0] MemReadData;
    logic [31:0] MemorIO_Result;

    modport master (
        output IORead,
        output IOWrite,
        output ALU_result,
        output Read_data_2,
        output MemReadData,
        input  MemorIO_Result
    );

    modport slave (
        input  IORead,
        input  IOWrite,
        input  ALU_result,
        input  Read_data_2,
        input  MemReadData,
        output MemorIO_Result
    );
endinterface

// File: rtl/io_module.sv
// Memory-mapped I/O controller: LED/7-seg/blink store registers, switch and button loads.
// Optional macro IO_READBACK_EN: loads at the store offsets return the stored registers.
module io_module #(
    parameter logic [23:0] IO_BASE = 24'hFFFFFC
) (
    input  logic               clk,
    input  logic               rst_n,
    io_module_if.slave         bus,
    input  logic [7:0]         IO_input,
    input  logic [2:0]         TEST_input,
    input  logic               enterA,
    input  logic               enterB,
    output logic [23:0]        IO_led_out,
    output logic [23:0]        IO_seg_out,
    output logic               IO_blink_out
);

    localparam logic [7:0] OFF_LED   = 8'h60;
    localparam logic [7:0] OFF_SEG   = 8'h64;
    localparam logic [7:0] OFF_BLINK = 8'h68;
    localparam logic [7:0] OFF_SW    = 8'h70;
    localparam logic [7:0] OFF_TEST  = 8'h74;
    localparam logic [7:0] OFF_BTNA  = 8'h78;
    localparam logic [7:0] OFF_BTNB  = 8'h7C;

    logic        sel;
    logic [7:0]  off;
    logic        wr_en;
    logic        rd_en;
    logic        hit_led;
    logic        hit_seg;
    logic        hit_blink;
    logic        hit_sw;
    logic        hit_test;
    logic        hit_btna;
    logic        hit_btnb;
    logic [31:0] io_rdata;

    logic [23:0] led_q,   led_d;
    logic [23:0] seg_q,   seg_d;
    logic        blink_q, blink_d;
    logic        flag_a_q, flag_a_d;
    logic        flag_b_q, flag_b_d;
    logic        prev_a_q;
    logic        prev_b_q;
    logic        rise_a;
    logic        rise_b;
    logic        clr_a;
    logic        clr_b;

    // Address decode: upper 24 bits select the I/O page, low byte is the register offset
    always_comb begin
        sel       = (bus.ALU_result[31:8] == IO_BASE);
        off       = bus.ALU_result[7:0];
        wr_en     = bus.IOWrite & sel;
        rd_en     = bus.IORead & sel;
        hit_led   = (off == OFF_LED);
        hit_seg   = (off == OFF_SEG);
        hit_blink = (off == OFF_BLINK);
        hit_sw    = (off == OFF_SW);
        hit_test  = (off == OFF_TEST);
        hit_btna  = (off == OFF_BTNA);
        hit_btnb  = (off == OFF_BTNB);
    end

    // Load data mux; unmapped offsets and off-page accesses read as zero
    always_comb begin
        io_rdata = 32'b0;
        if (rd_en) begin
            unique case (1'b1)
                hit_sw:    io_rdata = {24'b0, IO_input};
                hit_test:  io_rdata = {29'b0, TEST_input};
                hit_btna:  io_rdata = {31'b0, flag_a_q};
                hit_btnb:  io_rdata = {31'b0, flag_b_q};
`ifdef IO_READBACK_EN
                hit_led:   io_rdata = {8'b0, led_q};
                hit_seg:   io_rdata = {8'b0, seg_q};
                hit_blink: io_rdata = {31'b0, blink_q};
`endif
                default:   io_rdata = 32'b0;
            endcase
        end
    end

    // Writeback select: I/O loads take priority over data memory
    always_comb begin
        bus.MemorIO_Result = bus.IORead ? io_rdata : bus.MemReadData;
    end

    // Store register next-state: only a matching on-page store changes a register
    always_comb begin
        led_d   = led_q;
        seg_d   = seg_q;
        blink_d = blink_q;
        if (wr_en) begin
            unique case (1'b1)
                hit_led:   led_d   = bus.Read_data_2[23:0];
                hit_seg:   seg_d   = bus.Read_data_2[23:0];
                hit_blink: blink_d = bus.Read_data_2[0];
                default:   ;
            endcase
        end
    end

    // Button flags: set on a rising edge, cleared by reading, a new press beats the clear
    always_comb begin
        rise_a   = enterA & ~prev_a_q;
        rise_b   = enterB & ~prev_b_q;
        clr_a    = rd_en & hit_btna;
        clr_b    = rd_en & hit_btnb;
        flag_a_d = rise_a | (flag_a_q & ~clr_a);
        flag_b_d = rise_b | (flag_b_q & ~clr_b);
    end

    // Peripheral output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= 24'b0;
            seg_q   <= 24'b0;
            blink_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            seg_q   <= seg_d;
            blink_q <= blink_d;
        end
    end

    // Button edge history and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            prev_a_q <= enterA;
            prev_b_q <= enterB;
            flag_a_q <= flag_a_d;
            flag_b_q <= flag_b_d;
        end
    end

    assign IO_led_out   = led_q;
    assign IO_seg_out   = seg_q;
    assign IO_blink_out = blink_q;

endmodule

// File: tb/tb_io_module.sv
// Self-checking bench for io_module: directed literal checks plus randomized
// traffic compared every cycle against a register-map model.
module tb_io_module;

    logic        clk;
    logic        rst_n;
    logic [7:0]  IO_input;
    logic [2:0]  TEST_input;
    logic        enterA;
    logic        enterB;
    logic [23:0] IO_led_out;
    logic [23:0] IO_seg_out;
    logic        IO_blink_out;

    io_module_if bus();

    io_module dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .IO_input     (IO_input),
        .TEST_input   (TEST_input),
        .enterA       (enterA),
        .enterB       (enterB),
        .IO_led_out   (IO_led_out),
        .IO_seg_out   (IO_seg_out),
        .IO_blink_out (IO_blink_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference state of the peripheral register map
    logic [23:0] m_led;
    logic [23:0] m_seg;
    logic        m_blink;
    logic        m_fa;
    logic        m_fb;
    logic        m_pa;
    logic        m_pb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_led = '0; m_seg = '0; m_blink = 1'b0;
        m_fa = 1'b0; m_fb = 1'b0; m_pa = 1'b0; m_pb = 1'b0;
    endtask

    function automatic logic [31:0] m_result();
        logic [31:0] r;
        logic        s;
        s = (bus.ALU_result[31:8] == 24'hFFFFFC);
        if (!bus.IORead) return bus.MemReadData;
        if (!s) return 32'h0;
        case (bus.ALU_result[7:0])
            8'h70: r = {24'h0, IO_input};
            8'h74: r = {29'h0, TEST_input};
            8'h78: r = {31'h0, m_fa};
            8'h7C: r = {31'h0, m_fb};
`ifdef IO_READBACK_EN
            8'h60: r = {8'h0, m_led};
            8'h64: r = {8'h0, m_seg};
            8'h68: r = {31'h0, m_blink};
`endif
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic m_edge();
        logic       s;
        logic [7:0] o;
        logic       ra;
        logic       rb;
        if (!rst_n) begin
            m_reset();
            return;
        end
        s  = (bus.ALU_result[31:8] == 24'hFFFFFC);
        o  = bus.ALU_result[7:0];
        ra = enterA && !m_pa;
        rb = enterB && !m_pb;
        if (bus.IORead && s && o == 8'h78) m_fa = 1'b0;
        if (bus.IORead && s && o == 8'h7C) m_fb = 1'b0;
        if (ra) m_fa = 1'b1;
        if (rb) m_fb = 1'b1;
        m_pa = enterA;
        m_pb = enterB;
        if (bus.IOWrite && s) begin
            if (o == 8'h60) m_led = bus.Read_data_2[23:0];
            if (o == 8'h64) m_seg = bus.Read_data_2[23:0];
            if (o == 8'h68) m_blink = bus.Read_data_2[0];
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, settle
    task automatic tick();
        @(negedge clk);
        chk("result", bus.MemorIO_Result, m_result());
        chk("led", {8'h0, IO_led_out}, {8'h0, m_led});
        chk("seg", {8'h0, IO_seg_out}, {8'h0, m_seg});
        chk("blink", {31'h0, IO_blink_out}, {31'h0, m_blink});
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        bus.IORead = 1'b0;
        bus.IOWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.IOWrite = 1'b0;
        bus.IORead = 1'b1;
        bus.ALU_result = a;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.IORead = 1'b0;
        bus.IOWrite = 1'b1;
        bus.ALU_result = a;
        bus.Read_data_2 = d;
    endtask

    logic [7:0] offs [10];

    initial begin
        tests = 0;
        fails = 0;
        offs = '{8'h60, 8'h64, 8'h68, 8'h6C, 8'h70,
                 8'h74, 8'h78, 8'h7C, 8'h80, 8'h00};
        rst_n = 1'b0;
        bus.IORead = 1'b0;
        bus.IOWrite = 1'b0;
        bus.ALU_result = '0;
        bus.Read_data_2 = '0;
        bus.MemReadData = '0;
        IO_input = '0;
        TEST_input = '0;
        enterA = 1'b0;
        enterB = 1'b0;
        m_reset();
        #3;
        chk("rst_led", {8'h0, IO_led_out}, 32'h0);
        chk("rst_seg", {8'h0, IO_seg_out}, 32'h0);
        chk("rst_blink", {31'h0, IO_blink_out}, 32'h0);
        rd(32'hFFFFFC78);
        #1;
        chk("rst_flag_rd", bus.MemorIO_Result, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        wr(32'hFFFFFC60, 32'h00A5A5A5);
        tick();
        idle();
        #1;
        chk("led_store", {8'h0, IO_led_out}, 32'h00A5A5A5);
        wr(32'h0000FC60, 32'h00111111);
        tick();
        idle();
        #1;
        chk("led_offpage", {8'h0, IO_led_out}, 32'h00A5A5A5);

        IO_input = 8'h3C;
        TEST_input = 3'b101;
        rd(32'hFFFFFC70);
        #1;
        chk("rd_sw", bus.MemorIO_Result, 32'h0000003C);
        tick();
        rd(32'hFFFFFC74);
        #1;
        chk("rd_test", bus.MemorIO_Result, 32'h00000005);
        tick();
        idle();
        bus.MemReadData = 32'h12345678;
        #1;
        chk("rd_mem", bus.MemorIO_Result, 32'h12345678);
        tick();

        enterA = 1'b1;
        repeat (10) tick();
        rd(32'hFFFFFC78);
        #1;
        chk("flagA_set", bus.MemorIO_Result, 32'h1);
        tick();
        #1;
        chk("flagA_held", bus.MemorIO_Result, 32'h0);
        idle();
        enterA = 1'b0;
        tick();
        enterA = 1'b1;
        tick();
        rd(32'hFFFFFC78);
        #1;
        chk("flagA_repress", bus.MemorIO_Result, 32'h1);
        tick();

        idle();
        enterB = 1'b1;
        tick();
        enterB = 1'b0;
        tick();
        enterB = 1'b1;
        rd(32'hFFFFFC7C);
        tick();
        #1;
        chk("flagB_setwins", bus.MemorIO_Result, 32'h1);
        tick();
        #1;
        chk("flagB_cleared", bus.MemorIO_Result, 32'h0);

        wr(32'hFFFFFC64, 32'h00000123);
        tick();
        rd(32'hFFFFFC64);
        #1;
        chk("seg_store", {8'h0, IO_seg_out}, 32'h00000123);
`ifdef IO_READBACK_EN
        chk("seg_readback", bus.MemorIO_Result, 32'h00000123);
`else
        chk("seg_readback", bus.MemorIO_Result, 32'h0);
`endif
        tick();

        for (int i = 0; i < 3000; i++) begin
            bus.IORead = 1'($urandom_range(0, 1));
            bus.IOWrite = 1'($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 8)
                bus.ALU_result = {24'hFFFFFC, offs[$urandom_range(0, 9)]};
            else
                bus.ALU_result = $urandom;
            bus.Read_data_2 = $urandom;
            bus.MemReadData = $urandom;
            IO_input = 8'($urandom);
            TEST_input = 3'($urandom);
            if ($urandom_range(0, 4) == 0) enterA = ~enterA;
            if ($urandom_range(0, 4) == 0) enterB = ~enterB;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                m_reset();
                chk("async_rst_led", {8'h0, IO_led_out}, 32'h0);
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
